// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the round-robin arbiter and the fifo write port.
// The arbiter connects through the slave modport; producers and the fifo connect through master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      grant_vld;
  logic [ID_W-1:0]           grant_id;
  logic                      burst_done;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, burst_done
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, burst_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer per burst (ended by last or MAX_BURST beats)
// and passes its beats straight through to the fifo write port, stalling while the fifo is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_d;
  logic [ID_W-1:0]    grant_id, grant_id_d;
  logic               grant_vld, grant_vld_d;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_d;
  logic [ID_W-1:0]    last_grant, last_grant_d;
  logic               burst_done, burst_done_d;

  logic [ID_W-1:0]    rr_pick;
  logic [ID_W-1:0]    rr_cand;
  logic               beat;
  logic               burst_end;
  logic               wr_en;
  logic [NUM_REQ-1:0] ready;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  // Round-robin search: walk backwards so the final assignment is the first valid
  // index after last_grant, which avoids a separate found flag.
  always_comb begin
    rr_pick = '0;
    rr_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (bus.req_valid[rr_cand]) rr_pick = rr_cand;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign beat      = bus.req_valid[grant_id] & ~bus.fifo_full;
  assign burst_end = bus.req_last[grant_id] | (beat_cnt == CNT_W'(MAX_BURST - 1));

  // State register. The reset aborts a burst in flight; the producer simply re-arbitrates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      grant_vld  <= 1'b0;
      beat_cnt   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      burst_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state      <= state_d;
      grant_id   <= grant_id_d;
      grant_vld  <= grant_vld_d;
      beat_cnt   <= beat_cnt_d;
      last_grant <= last_grant_d;
      burst_done <= burst_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d      = state;
    grant_id_d   = grant_id;
    grant_vld_d  = grant_vld;
    beat_cnt_d   = beat_cnt;
    last_grant_d = last_grant;
    burst_done_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d     = BURST;
          grant_id_d  = rr_pick;
          grant_vld_d = 1'b1;
          beat_cnt_d  = '0;
        end
      end
      BURST: begin
        if (beat) begin
          if (burst_end) begin
            state_d      = IDLE;
            grant_vld_d  = 1'b0;
            last_grant_d = grant_id;
            burst_done_d = 1'b1;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: zero-latency pass-through from the granted producer to the fifo.
  always_comb begin
    wr_en = (state == BURST) & beat;
    ready = '0;
    if (wr_en) ready[grant_id] = 1'b1;
  end

  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = data_arr[grant_id];
  assign bus.req_ready    = ready;
  assign bus.grant_vld    = grant_vld;
  assign bus.grant_id     = grant_id;
  assign bus.burst_done   = burst_done;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: expected fifo writes are queued as stimulus is set up
// and a negedge monitor pops and compares them whenever the arbiter writes.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  // Scoreboard monitor.
  always @(negedge clk) begin
    beat_t e;
    if (bus.fifo_wr_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra_write: got id=%0d data=%h, required no write", bus.grant_id, bus.fifo_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.grant_id !== e.id || bus.fifo_wr_data !== e.data || bus.req_ready !== (4'b0001 << e.id)) begin
          fails++;
          $display("FAIL sb_write: got id=%0d data=%h ready=%b, required id=%0d data=%h ready=%b",
                   bus.grant_id, bus.fifo_wr_data, bus.req_ready, e.id, e.data, 4'b0001 << e.id);
        end
      end
    end else if (rst) begin
      tests++;
      if (bus.req_ready !== '0) begin
        fails++;
        $display("FAIL ready_without_write: got %b, required 0000", bus.req_ready);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    bus.req_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '0;
    bus.req_data  = 32'h44332211;
    bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.fifo_wr_en, bus.req_ready, bus.grant_vld, bus.burst_done, bus.grant_id} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs: got wr_en=%b ready=%b gv=%b done=%b gid=%0d, required all 0",
               bus.fifo_wr_en, bus.req_ready, bus.grant_vld, bus.burst_done, bus.grant_id);
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    bus.req_valid = 4'b0001;
    for (int b = 0; b < 3; b++) exp_q.push_back({2'd0, 8'hA1 + 8'(b)});
    set_data(0, 8'hA1);
    @(negedge clk);
    tests++;
    if ({bus.fifo_wr_en, bus.grant_vld} !== 2'b00) begin
      fails++;
      $display("FAIL t2_idle_cycle: got wr_en=%b gv=%b, required 0 0", bus.fifo_wr_en, bus.grant_vld);
    end
    next_cycle();
    for (int b = 0; b < 3; b++) begin
      set_data(0, 8'hA1 + 8'(b));
      bus.req_last[0] = (b == 2);
      @(negedge clk);
      tests++;
      if ({bus.fifo_wr_en, bus.grant_vld, bus.grant_id, bus.burst_done} !== 5'b11000) begin
        fails++;
        $display("FAIL t2_beat%0d: got wr_en=%b gv=%b gid=%0d done=%b, required 1 1 0 0",
                 b, bus.fifo_wr_en, bus.grant_vld, bus.grant_id, bus.burst_done);
      end
      next_cycle();
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge clk);
    tests++;
    if ({bus.burst_done, bus.grant_vld, bus.fifo_wr_en} !== 3'b100) begin
      fails++;
      $display("FAIL t2_burst_done: got done=%b gv=%b wr_en=%b, required 1 0 0",
               bus.burst_done, bus.grant_vld, bus.fifo_wr_en);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (bus.burst_done !== 1'b0) begin
      fails++;
      $display("FAIL t2_done_one_cycle: got %b, required 0", bus.burst_done);
    end
  endtask

  task automatic test_round_robin_fill();
    int seq [NUM_REQ];
    int wr_cnt = 0, done_cnt = 0, last_wr = -1;
    apply_reset();
    foreach (seq[i]) seq[i] = 0;
    for (int g = 0; g < NUM_REQ; g++)
      for (int b = 0; b < MAX_BURST; b++) exp_q.push_back({ID_W'(g), DATA_W'(g*16 + b)});
    bus.req_valid = '1;
    for (int c = 0; c < 25; c++) begin
      bus.fifo_full = (wr_cnt >= 16);
      for (int i = 0; i < NUM_REQ; i++) set_data(i, DATA_W'(i*16 + seq[i]));
      @(negedge clk);
      if (bus.fifo_wr_en) begin
        wr_cnt++;
        last_wr = c;
      end
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) seq[i]++;
      if (bus.burst_done) done_cnt++;
      next_cycle();
    end
    tests++;
    if (wr_cnt !== 16 || last_wr !== 19) begin
      fails++;
      $display("FAIL t3_fill_timing: got %0d writes, last at cycle %0d; required 16, cycle 19", wr_cnt, last_wr);
    end
    tests++;
    if (done_cnt !== 4) begin
      fails++;
      $display("FAIL t3_burst_done_count: got %0d, required 4", done_cnt);
    end
    @(negedge clk);
    tests++;
    if ({bus.grant_vld, bus.grant_id, bus.fifo_wr_en} !== 4'b1000) begin
      fails++;
      $display("FAIL t3_full_stall: got gv=%b gid=%0d wr_en=%b, required 1 0 0",
               bus.grant_vld, bus.grant_id, bus.fifo_wr_en);
    end
  endtask

  task automatic test_fifo_full_stall();
    int  seq2 = 0;
    logic exp_wr, exp_gv;
    apply_reset();
    for (int b = 0; b < MAX_BURST; b++) exp_q.push_back({2'd2, 8'hC0 + 8'(b)});
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 8) ? 4'b0100 : 4'b0000;
      bus.fifo_full = (c >= 3 && c <= 5);
      set_data(2, 8'hC0 + 8'(seq2));
      @(negedge clk);
      exp_wr = (c == 1 || c == 2 || c == 6 || c == 7);
      exp_gv = (c >= 1 && c <= 7);
      tests++;
      if ({bus.fifo_wr_en, bus.burst_done, bus.grant_vld} !== {exp_wr, c == 8, exp_gv} ||
          (exp_gv && bus.grant_id !== 2'd2)) begin
        fails++;
        $display("FAIL t4_cycle%0d: got wr_en=%b done=%b gv=%b gid=%0d, required %b %b %b 2",
                 c, bus.fifo_wr_en, bus.burst_done, bus.grant_vld, bus.grant_id, exp_wr, c == 8, exp_gv);
      end
      if (bus.req_ready[2]) seq2++;
      next_cycle();
    end
  endtask

  task automatic test_sparse_valid();
    int  seq1 = 0;
    logic exp_wr, exp_gv;
    apply_reset();
    for (int b = 0; b < MAX_BURST; b++) exp_q.push_back({2'd1, 8'hD0 + 8'(b)});
    for (int c = 0; c < 11; c++) begin
      bus.req_valid[1] = (c % 2 == 0) && (c <= 8);
      bus.req_valid[0] = (c >= 1 && c <= 8);
      bus.req_last[0]  = 1'b1;
      set_data(1, 8'hD0 + 8'(seq1));
      set_data(0, 8'hEE);
      @(negedge clk);
      exp_wr = (c == 2 || c == 4 || c == 6 || c == 8);
      exp_gv = (c >= 1 && c <= 8);
      tests++;
      if ({bus.fifo_wr_en, bus.burst_done, bus.grant_vld} !== {exp_wr, c == 9, exp_gv} ||
          (exp_gv && bus.grant_id !== 2'd1)) begin
        fails++;
        $display("FAIL t5_cycle%0d: got wr_en=%b done=%b gv=%b gid=%0d, required %b %b %b 1",
                 c, bus.fifo_wr_en, bus.burst_done, bus.grant_vld, bus.grant_id, exp_wr, c == 9, exp_gv);
      end
      if (bus.req_ready[1]) seq1++;
      next_cycle();
    end
    bus.req_last = '0;
  endtask

  task automatic test_single_requester();
    int  seq0 = 0, done_cnt = 0;
    logic exp_wr;
    apply_reset();
    for (int b = 0; b < 8; b++) exp_q.push_back({2'd0, 8'hF0 + 8'(b)});
    for (int c = 0; c < 12; c++) begin
      bus.req_valid[0] = (seq0 < 8);
      bus.req_last[0]  = (seq0 == 3) || (c == 5);
      set_data(0, 8'hF0 + 8'(seq0));
      @(negedge clk);
      exp_wr = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      tests++;
      if ({bus.fifo_wr_en, bus.grant_vld} !== {exp_wr, exp_wr} || bus.burst_done !== (c == 5 || c == 10)) begin
        fails++;
        $display("FAIL t6_cycle%0d: got wr_en=%b gv=%b done=%b, required %b %b %b",
                 c, bus.fifo_wr_en, bus.grant_vld, bus.burst_done, exp_wr, exp_wr, c == 5 || c == 10);
      end
      if (bus.burst_done) done_cnt++;
      if (bus.req_ready[0]) seq0++;
      next_cycle();
    end
    tests++;
    if (done_cnt !== 2) begin
      fails++;
      $display("FAIL t6_done_count: got %0d, required 2", done_cnt);
    end
    bus.req_last = '0;
  endtask

  task automatic test_reset_mid_burst();
    int seq0 = 0;
    apply_reset();
    exp_q.push_back({2'd0, 8'hE0});
    exp_q.push_back({2'd0, 8'hE1});
    bus.req_valid = 4'b0011;
    set_data(1, 8'h55);
    for (int c = 0; c < 3; c++) begin
      set_data(0, 8'hE0 + 8'(seq0));
      @(negedge clk);
      if (bus.req_ready[0]) seq0++;
      next_cycle();
    end
    set_data(0, 8'hE2);
    #1;
    tests++;
    if (bus.fifo_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL t7_third_beat_offered: got wr_en=%b, required 1", bus.fifo_wr_en);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.fifo_wr_en, bus.req_ready, bus.grant_vld, bus.burst_done} !== 7'b0) begin
      fails++;
      $display("FAIL t7_async_abort: got wr_en=%b ready=%b gv=%b done=%b, required all 0",
               bus.fifo_wr_en, bus.req_ready, bus.grant_vld, bus.burst_done);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back({2'd0, 8'hE0});
    set_data(0, 8'hE0);
    @(negedge clk);
    tests++;
    if ({bus.fifo_wr_en, bus.grant_vld} !== 2'b00) begin
      fails++;
      $display("FAIL t7_idle_after_reset: got wr_en=%b gv=%b, required 0 0", bus.fifo_wr_en, bus.grant_vld);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if ({bus.fifo_wr_en, bus.grant_vld, bus.grant_id} !== 4'b1100) begin
      fails++;
      $display("FAIL t7_regrant_p0: got wr_en=%b gv=%b gid=%0d, required 1 1 0",
               bus.fifo_wr_en, bus.grant_vld, bus.grant_id);
    end
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin_fill();
    test_fifo_full_stall();
    test_sparse_valid();
    test_single_requester();
    test_reset_mid_burst();
    apply_reset();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL sb_missing_writes: got %0d writes still pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
